// File: rtl/csr_file_m.sv
// Machine-mode CSR file: CSRRW/RS/RC, trap entry, MRET and read-only IDs.
// Define CSR_MCYCLE_EN to add the free-running 64-bit mcycle counter.
module csr_file_m #(
    parameter int          XLEN          = 32,
    parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
    parameter logic [31:0] MSTATUS_RESET = 32'h0000_1800,
    parameter logic [31:0] VENDOR_ID     = 32'h0000_0000,
    parameter logic [31:0] ARCH_ID       = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret,
    output logic [XLEN-1:0] trap_target,
    output logic [XLEN-1:0] mepc_out
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MVENDOR  = 12'hF11;
    localparam logic [11:0] A_MARCH    = 12'hF12;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;

    localparam logic [XLEN-1:0] LOW_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic            mie;
    logic            mpie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;

    logic sel_mstatus, sel_mtvec, sel_mscratch;
    logic sel_mepc, sel_mcause, sel_vid, sel_aid;
    logic sel_cyc, sel_cych;
    logic implemented, read_only;
    logic is_write, do_write;

    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic [XLEN-1:0] mstatus_rd;
    logic [XLEN-1:0] cyc_lo;
    logic [XLEN-1:0] cyc_hi;

    assign sel_mstatus  = (csr_addr == A_MSTATUS);
    assign sel_mtvec    = (csr_addr == A_MTVEC);
    assign sel_mscratch = (csr_addr == A_MSCRATCH);
    assign sel_mepc     = (csr_addr == A_MEPC);
    assign sel_mcause   = (csr_addr == A_MCAUSE);
    assign sel_vid      = (csr_addr == A_MVENDOR);
    assign sel_aid      = (csr_addr == A_MARCH);

    // Only MIE/MPIE are stored; MPP is hardwired to machine mode.
    assign mstatus_rd = XLEN'({19'd0, 2'b11, 3'd0, mpie,
                               3'd0, mie, 3'd0});

    assign implemented = sel_mstatus | sel_mtvec | sel_mscratch |
                         sel_mepc | sel_mcause | sel_vid |
                         sel_aid | sel_cyc | sel_cych;
    assign read_only   = sel_vid | sel_aid;

    // RS/RC with a zero mask are pure reads.
    assign is_write = (csr_op == 2'b01) ||
                      (csr_op[1] && (csr_wdata != '0));

    assign illegal = (csr_op != 2'b00) &&
                     (!implemented || (read_only && is_write));

    assign do_write = is_write && !illegal && !trap_valid && !mret;

    always_comb begin
        old_val = '0;
        unique case (1'b1)
            sel_mstatus:  old_val = mstatus_rd;
            sel_mtvec:    old_val = mtvec;
            sel_mscratch: old_val = mscratch;
            sel_mepc:     old_val = mepc;
            sel_mcause:   old_val = mcause;
            sel_vid:      old_val = XLEN'(VENDOR_ID);
            sel_aid:      old_val = XLEN'(ARCH_ID);
            sel_cyc:      old_val = cyc_lo;
            sel_cych:     old_val = cyc_hi;
            default:      old_val = '0;
        endcase
    end

    always_comb begin
        new_val = old_val;
        case (csr_op)
            2'b01:   new_val = csr_wdata;
            2'b10:   new_val = old_val | csr_wdata;
            2'b11:   new_val = old_val & ~csr_wdata;
            default: new_val = old_val;
        endcase
    end

    assign csr_rdata = ((csr_op != 2'b00) && !illegal) ? old_val : '0;

    assign trap_target = mtvec & LOW_MASK;
    assign mepc_out    = mepc;

    always_ff @(posedge clk) begin
        if (rst) begin
            mie      <= MSTATUS_RESET[3];
            mpie     <= MSTATUS_RESET[7];
            mtvec    <= XLEN'(MTVEC_RESET);
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
        end else if (trap_valid) begin
            mepc   <= trap_pc & LOW_MASK;
            mcause <= trap_cause;
            mpie   <= mie;
            mie    <= 1'b0;
        end else if (mret) begin
            mie  <= mpie;
            mpie <= 1'b1;
        end else if (do_write) begin
            unique case (1'b1)
                sel_mstatus: begin
                    mie  <= new_val[3];
                    mpie <= new_val[7];
                end
                sel_mtvec:    mtvec    <= new_val;
                sel_mscratch: mscratch <= new_val;
                sel_mepc:     mepc     <= new_val & LOW_MASK;
                sel_mcause:   mcause   <= new_val;
                default: ;
            endcase
        end
    end

`ifdef CSR_MCYCLE_EN
    logic [63:0] mcycle;
    logic [63:0] mcycle_wr;
    logic        cyc_write;

    assign sel_cyc  = (csr_addr == A_MCYCLE);
    assign sel_cych = (XLEN == 32) && (csr_addr == A_MCYCLEH);

    assign cyc_lo = mcycle[XLEN-1:0];
    assign cyc_hi = XLEN'(mcycle[63:32]);

    assign cyc_write = do_write && (sel_cyc || sel_cych);

    always_comb begin
        mcycle_wr = mcycle;
        if (sel_cych)
            mcycle_wr[63:32] = new_val[31:0];
        else
            mcycle_wr[XLEN-1:0] = new_val;
    end

    // A software write replaces the counter instead of incrementing it.
    always_ff @(posedge clk) begin
        if (rst)
            mcycle <= '0;
        else if (cyc_write)
            mcycle <= mcycle_wr;
        else
            mcycle <= mcycle + 64'd1;
    end
`else
    assign sel_cyc  = 1'b0;
    assign sel_cych = 1'b0;
    assign cyc_lo   = '0;
    assign cyc_hi   = '0;
`endif

endmodule
